dmem_host_port: RTL and testbench

//  Host-side counterpart of the core's data-memory and done interface.
//  - Holds the core in reset, streams host words into dmem, then releases the core.
//  - Waits for core done, then streams a dmem window back to the host.
//  - Sits beside top, muxing the dmem port: host owns it when mem_sel=1, core when mem_sel=0.

---
 rtl/dmem_host_port_pkg.sv | 16 +
 rtl/host_addr_ctr.sv | 37 +++
 rtl/dmem_host_port.sv | 125 ++++++++++++
 tb/tb_dmem_host_port.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_host_port_pkg.sv
// Shared definitions for the dmem host port: FSM state encoding and default widths.
// Pure definitions; no latency or backpressure of its own.
package dmem_host_port_pkg;

  localparam int HOST_AW = 8;
  localparam int HOST_DW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DUMP  = 3'd4
  } host_state_t;

endpackage

// File: rtl/host_addr_ctr.sv
// Address/length walker shared by LOAD and DUMP: load base+len, step = addr++ (wrapping) and len--.
// Registered, 1-cycle update; no backpressure, the caller gates step.
module host_addr_ctr
  import dmem_host_port_pkg::*;
#(
  parameter int AW = HOST_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          zero
);

  logic [AW:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= base;
      cnt  <= len;
    end else if (step) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign last = (cnt == (AW+1)'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_host_port.sv
// Host side of the core dmem/done interface: LOAD words into dmem, RUN the core, DUMP a window back.
// LOAD/DUMP 1 word/cycle, first out_valid 1 cycle into DUMP; in/out valid-ready backpressure. Option: CYCLE_COUNT_EN.
module dmem_host_port
  import dmem_host_port_pkg::*;
#(
  parameter int AW    = HOST_AW,
  parameter int DW    = HOST_DW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    load_base,
  input  logic [AW:0]      load_len,
  input  logic [AW-1:0]    dump_base,
  input  logic [AW:0]      dump_len,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             core_reset,
  input  logic             core_done,
  output logic             mem_sel,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] run_cycles
);

  host_state_t   state;
  logic [AW-1:0] dump_base_q;
  logic [AW:0]   dump_len_q;
  logic          first_run;
  logic          ctr_load, ctr_step, ctr_last, ctr_zero;
  logic [AW-1:0] ctr_addr, ctr_base;
  logic [AW:0]   ctr_len;
  logic          wr_fire, rd_fire, rd_fetch;

  assign wr_fire  = (state == LOAD) && in_valid;
  assign rd_fire  = out_valid && out_ready;
  // Refill the output register on entry and on every handshake while words remain.
  assign rd_fetch = (state == DUMP) && !ctr_zero && (!out_valid || out_ready);

  assign ctr_load = ((state == IDLE) && start) || (state == DRAIN);
  assign ctr_base = (state == DRAIN) ? dump_base_q : load_base;
  assign ctr_len  = (state == DRAIN) ? dump_len_q : load_len;
  assign ctr_step = wr_fire || rd_fetch;

  host_addr_ctr #(.AW(AW)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .step  (ctr_step),
    .base  (ctr_base),
    .len   (ctr_len),
    .addr  (ctr_addr),
    .last  (ctr_last),
    .zero  (ctr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      first_run   <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      // High only during the first RUN cycle, masking core_done while the PC settles.
      first_run <= (state != RUN);
      case (state)
        IDLE: if (start) begin
          dump_base_q <= dump_base;
          dump_len_q  <= dump_len;
          state       <= (load_len == '0) ? RUN : LOAD;
        end
        LOAD: if (wr_fire && ctr_last) state <= RUN;
        RUN: if (core_done && !first_run) state <= DRAIN;
        DRAIN: state <= (dump_len_q == '0) ? IDLE : DUMP;
        DUMP: begin
          if (rd_fetch) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
          end else if (rd_fire) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == LOAD);
  assign mem_we     = wr_fire;
  assign mem_addr   = ctr_addr;
  assign mem_wdata  = wr_fire ? in_data : '0;
  assign core_reset = (state != RUN);
  assign mem_sel    = (state != RUN);
  assign busy       = (state != IDLE);

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      run_cnt <= '0;
    end else if ((state == RUN) && (run_cnt != '1)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign run_cycles = run_cnt;
`else
  assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_dmem_host_port.sv
// Directed bench for dmem_host_port: bench-side dmem, write/read scoreboards and literal pins.
module tb_dmem_host_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] load_base, dump_base;
  logic [8:0] load_len, dump_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       core_reset;
  logic       core_done;
  logic       mem_sel;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;
  logic [3:0] run_cycles;

  int total = 0;
  int bad   = 0;

  logic [7:0]  dmem [256];
  logic [7:0]  model_mem [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  got_rd [$];

  dmem_host_port #(.AW(8), .DW(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_base  (load_base),
    .load_len   (load_len),
    .dump_base  (dump_base),
    .dump_len   (dump_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .core_reset (core_reset),
    .core_done  (core_done),
    .mem_sel    (mem_sel),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_sel && mem_we) dmem[mem_addr] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_rc(input int n);
`ifdef CYCLE_COUNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0;
`endif
  endfunction

  // Every-cycle compare against the scoreboards, sampled mid-cycle after the negedge drive.
  logic       held = 1'b0;
  logic [7:0] held_d = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("sel_vs_core_reset", mem_sel, core_reset);
        if (exp_wr.size() == 0) begin
          chk("no_write_expected", mem_we, 0);
        end else if (mem_we) begin
          chk("wr_addr", mem_addr, exp_wr[0][15:8]);
          chk("wr_data", mem_wdata, exp_wr[0][7:0]);
          void'(exp_wr.pop_front());
        end
        if (exp_rd.size() == 0) begin
          chk("no_out_expected", out_valid, 0);
        end else if (out_valid) begin
          if (held) chk("out_hold", out_data, held_d);
          chk("rd_data", out_data, exp_rd[0]);
          if (out_ready) begin
            got_rd.push_back(out_data);
            void'(exp_rd.pop_front());
          end
        end
        held   = out_valid && !out_ready;
        held_d = out_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic start_op(input logic [7:0] lb, input int ll, input logic [7:0] db, input int dl);
    @(negedge clk);
    load_base = lb;
    load_len  = 9'(ll);
    dump_base = db;
    dump_len  = 9'(dl);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input logic [7:0] base, input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      int t;
      a = base + 8'(i);
      d = d0 + 8'(i);
      exp_wr.push_back({a, d});
      model_mem[a] = d;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    chk("run_1cyc_after_load", core_reset, 0);
  endtask

  // Entered at RUN cycle 1; core_done raised in RUN cycle n.
  task automatic run_phase(input int n, input bit poke);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      start = poke && (i == 1);
      if (poke && i == 1) begin
        load_base = 8'h80;
        load_len  = 9'd5;
        dump_len  = 9'd0;
      end
    end
    start     = 1'b0;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    #2;
    chk("drain_core_reset", core_reset, 1);
    chk("run_cycles", run_cycles, exp_rc(n));
  endtask

  task automatic dump_phase(input logic [7:0] db, input int dl, input bit toggle);
    int t;
    for (int i = 0; i < dl; i++) begin
      logic [7:0] a;
      a = db + 8'(i);
      exp_rd.push_back(model_mem[a]);
    end
    t = 0;
    do begin
      @(negedge clk);
      out_ready = toggle ? t[0] : 1'b1;
      t++;
      #1;
    end while (busy && t < 100);
    out_ready = 1'b0;
    chk("dump_done_idle", busy, 0);
    chk("dump_all_words", exp_rd.size(), 0);
    chk("idle_core_reset", core_reset, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_mem_sel"}, mem_sel, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; load_base = '0; load_len = '0; dump_base = '0; dump_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_done = 1'b0;
    #1;
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Load 0x10..0x12, 20-cycle run, dump with stalling host.
    start_op(8'h10, 3, 8'h10, 3);
    load_words(8'h10, 3, 8'hA1);
    run_phase(20, 1'b0);
    dump_phase(8'h10, 3, 1'b1);
    chk("op1_nwords", got_rd.size(), 3);
    chk("op1_w0", got_rd[0], 8'hA1);
    chk("op1_w1", got_rd[1], 8'hA2);
    chk("op1_w2", got_rd[2], 8'hA3);
    chk("op1_run_cycles", run_cycles, exp_rc(20));
    got_rd.delete();

    // Wrapping load and dump across 0xFF; stray start during RUN must be ignored.
    start_op(8'hFE, 3, 8'hFE, 3);
    load_words(8'hFE, 3, 8'hB1);
    run_phase(5, 1'b1);
    dump_phase(8'hFE, 3, 1'b0);
    chk("wrap_fe", dmem[8'hFE], 8'hB1);
    chk("wrap_ff", dmem[8'hFF], 8'hB2);
    chk("wrap_00", dmem[8'h00], 8'hB3);
    chk("op2_w2", got_rd[2], 8'hB3);
    got_rd.delete();

    // Zero lengths with core_done already high: done masked in RUN cycle 1.
    core_done = 1'b1;
    start_op(8'h00, 0, 8'h00, 0);
    #2; chk("z_run1", core_reset, 0);
    @(negedge clk); #2; chk("z_run2_done_masked", core_reset, 0);
    @(negedge clk); #2; chk("z_drain", core_reset, 1); chk("z_drain_busy", busy, 1);
    core_done = 1'b0;
    @(negedge clk); #2; chk("z_idle", busy, 0);
    chk("z_run_cycles", run_cycles, exp_rc(2));

    // Reset while word 2 of a load is presented.
    start_op(8'h40, 3, 8'h40, 2);
    exp_wr.push_back({8'h40, 8'hD1});
    model_mem[8'h40] = 8'hD1;
    in_valid = 1'b1; in_data = 8'hD1;
    @(negedge clk);
    in_data = 8'hD2;
    reset = 1'b0;
    exp_wr.delete();
    #1;
    chk_reset_vals("mid");
    @(posedge clk); #1;
    chk_reset_vals("mid_edge");
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    chk("d1_kept", dmem[8'h40], 8'hD1);

    // Clean restart after the mid-op reset.
    start_op(8'h41, 2, 8'h40, 3);
    load_words(8'h41, 2, 8'hE1);
    run_phase(3, 1'b0);
    dump_phase(8'h40, 3, 1'b0);
    chk("op5_w0", got_rd[0], 8'hD1);
    chk("op5_w1", got_rd[1], 8'hE1);
    chk("op5_w2", got_rd[2], 8'hE2);
    chk("final_wq_empty", exp_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
